// File: rtl/mem_stage_fsm.sv
// MEM pipeline stage: data-memory load/store over a req/ack port, load
// alignment and extension, branch/jump redirect resolution, and the
// writeback-facing output register.
module mem_stage_fsm #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       IR_in,
  input  logic [31:0]       ALU_in,
  input  logic              COMP_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       B_in,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              out_valid,
  output logic [31:0]       IR_out,
  output logic [31:0]       ALU_out,
  output logic [31:0]       LMD_out,
  output logic [31:0]       PC_out,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              misalign_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, state_nxt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_mem;
  logic        misaligned;
  logic        accept_pass, accept_mem, complete;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] ir_q, alu_q, pc_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign opcode    = IR_in[6:0];
  assign funct3    = IR_in[14:12];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_mem    = is_load | is_store;

  // Access size comes from funct3[1:0]: 00 byte, 01 halfword, 1x word
  // (so unsupported load encodings fall into the word path).
  assign misaligned = is_mem &
                      (((funct3[1:0] == 2'b01) & ALU_in[0]) |
                       (funct3[1] & (ALU_in[1:0] != 2'b00)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, stall and accept/complete strobes.
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    accept_pass = 1'b0;
    accept_mem  = 1'b0;
    complete    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mem && !misaligned) begin
            stall      = 1'b1;
            accept_mem = 1'b1;
            state_nxt  = S_WAIT;
          end else begin
            accept_pass = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!rst_n) stall = 1'b0;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = B_in;
    case (funct3[1:0])
      2'b00: begin
        store_be    = 4'b0001 << ALU_in[1:0];
        store_wdata = {4{B_in[7:0]}};
      end
      2'b01: begin
        store_be    = ALU_in[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{B_in[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = B_in;
      end
    endcase
  end

  // Lane select and sign/zero extension of returning load data.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (alu_q[1:0])
      2'b00: ld_byte = dmem_rdata[7:0];
      2'b01: ld_byte = dmem_rdata[15:8];
      2'b10: ld_byte = dmem_rdata[23:16];
      2'b11: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ir_q[13:12])
      2'b00:   load_data = {{24{ld_byte[7] & ~ir_q[14]}}, ld_byte};
      2'b01:   load_data = {{16{ld_half[15] & ~ir_q[14]}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Memory request, in-flight instruction latch and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      ir_q         <= '0;
      alu_q        <= '0;
      pc_q         <= '0;
      out_valid    <= 1'b0;
      IR_out       <= '0;
      ALU_out      <= '0;
      LMD_out      <= '0;
      PC_out       <= RESET_PC;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      misalign_err <= 1'b0;
    end else begin
      out_valid <= accept_pass | complete;
      if (accept_pass) begin
        IR_out       <= IR_in;
        ALU_out      <= (is_jal | is_jalr) ? PC_in + 32'd4 : ALU_in;
        LMD_out      <= '0;
        PC_out       <= PC_in;
        redirect     <= (is_branch & COMP_in) | is_jal | is_jalr;
        redirect_pc  <= is_jalr ? {ALU_in[31:1], 1'b0} : ALU_in;
        misalign_err <= misaligned;
      end
      if (accept_mem) begin
        ir_q       <= IR_in;
        alu_q      <= ALU_in;
        pc_q       <= PC_in;
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {ALU_in[ADDR_W-1:2], 2'b00};
        dmem_be    <= is_store ? store_be : 4'b1111;
        dmem_wdata <= is_store ? store_wdata : '0;
      end
      if (complete) begin
        dmem_req     <= 1'b0;
        IR_out       <= ir_q;
        ALU_out      <= alu_q;
        LMD_out      <= dmem_we ? '0 : load_data;
        PC_out       <= pc_q;
        redirect     <= 1'b0;
        redirect_pc  <= alu_q;
        misalign_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_fsm.sv
// Directed self-checking bench for mem_stage_fsm.
module tb_mem_stage_fsm;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk, rst_n;
  logic        in_valid, COMP_in, dmem_ack;
  logic [31:0] IR_in, ALU_in, PC_in, B_in, dmem_rdata;
  logic        stall, dmem_req, dmem_we, out_valid, redirect, misalign_err;
  logic [31:0] dmem_addr, dmem_wdata, IR_out, ALU_out, LMD_out, PC_out, redirect_pc;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  mem_stage_fsm #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .IR_in(IR_in), .ALU_in(ALU_in),
    .COMP_in(COMP_in), .PC_in(PC_in), .B_in(B_in), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid), .IR_out(IR_out),
    .ALU_out(ALU_out), .LMD_out(LMD_out), .PC_out(PC_out), .redirect(redirect),
    .redirect_pc(redirect_pc), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", dmem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (PC_out !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", PC_out, RST_PC); end
    checks++; if ({IR_out, ALU_out, LMD_out, redirect_pc} !== 128'h0) begin errors++; $display("FAIL reset_regs got %h/%h/%h/%h exp 0", IR_out, ALU_out, LMD_out, redirect_pc); end
    checks++; if ({dmem_addr, dmem_be, dmem_wdata, dmem_we, redirect, misalign_err} !== 71'h0) begin errors++; $display("FAIL reset_dmem got %h/%b/%h exp 0", dmem_addr, dmem_be, dmem_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; IR_in = 32'h0000_00B3; ALU_in = 32'h1234 + i; PC_in = 32'h10 + 4 * i;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall[%0d] got %b exp 0", i, stall); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL add_req[%0d] got %b exp 0", i, dmem_req); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (ALU_out !== 32'h1234 + i) begin errors++; $display("FAIL add_alu[%0d] got %h exp %h", i, ALU_out, 32'h1234 + i); end
      checks++; if (LMD_out !== 32'h0) begin errors++; $display("FAIL add_lmd[%0d] got %h exp 0", i, LMD_out); end
      checks++; if (PC_out !== 32'h10 + 4 * i) begin errors++; $display("FAIL add_pc[%0d] got %h exp %h", i, PC_out, 32'h10 + 4 * i); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_idle_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input int unsigned waits, input logic [31:0] exp_lmd);
    int unsigned stall_cycles;
    logic [31:0] ir;
    stall_cycles = 0;
    ir = {17'h0, f3, 5'd2, 7'b0000011};
    in_valid = 1'b1; IR_in = ir; ALU_in = addr; PC_in = 32'h40; B_in = 32'h0;
    dmem_rdata = 32'h0; dmem_ack = 1'b0;
    #1;
    if (stall) stall_cycles++;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL %s_req_early got %b exp 0", name, dmem_req); end
    for (int unsigned w = 1; w <= waits; w++) begin
      tick();
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL %s_req[%0d] got %b exp 1", name, w, dmem_req); end
      checks++; if (dmem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr[%0d] got %h exp %h", name, w, dmem_addr, {addr[31:2], 2'b00}); end
      checks++; if ({dmem_we, dmem_be} !== 5'b0_1111) begin errors++; $display("FAIL %s_we_be[%0d] got %b%b exp 01111", name, w, dmem_we, dmem_be); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_wait_out_valid[%0d] got %b exp 0", name, w, out_valid); end
      if (w == waits) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      #1;
      if (stall) stall_cycles++;
    end
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid got %b exp 1", name, out_valid); end
    checks++; if (LMD_out !== exp_lmd) begin errors++; $display("FAIL %s_lmd got %h exp %h", name, LMD_out, exp_lmd); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL %s_req_drop got %b exp 0", name, dmem_req); end
    checks++; if ({IR_out, ALU_out} !== {ir, addr}) begin errors++; $display("FAIL %s_ir_alu got %h/%h exp %h/%h", name, IR_out, ALU_out, ir, addr); end
    checks++; if (stall_cycles != waits + 1) begin errors++; $display("FAIL %s_stall_cycles got %0d exp %0d", name, stall_cycles, waits + 1); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse got %b exp 0", name, out_valid); end
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] bdata, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    in_valid = 1'b1; IR_in = {17'h0, f3, 5'd0, 7'b0100011}; ALU_in = addr; PC_in = 32'h88; B_in = bdata;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s_stall got %b exp 1", name, stall); end
    tick();
    checks++; if ({dmem_req, dmem_we} !== 2'b11) begin errors++; $display("FAIL %s_req_we got %b%b exp 11", name, dmem_req, dmem_we); end
    checks++; if (dmem_be !== exp_be) begin errors++; $display("FAIL %s_be got %b exp %b", name, dmem_be, exp_be); end
    checks++; if (dmem_wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata got %h exp %h", name, dmem_wdata, exp_wdata); end
    checks++; if (dmem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr got %h exp %h", name, dmem_addr, {addr[31:2], 2'b00}); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid got %b exp 1", name, out_valid); end
    checks++; if ({dmem_req, LMD_out} !== 33'h0) begin errors++; $display("FAIL %s_done got req %b lmd %h exp 0/0", name, dmem_req, LMD_out); end
    checks++; if ({ALU_out, PC_out} !== {addr, 32'h88}) begin errors++; $display("FAIL %s_alu_pc got %h/%h exp %h/88", name, ALU_out, PC_out, addr); end
    tick();
  endtask

  task automatic test_misalign(input string name, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
    in_valid = 1'b1; IR_in = {17'h0, f3, 5'd3, op}; ALU_in = addr; PC_in = 32'h60; B_in = 32'h1111_2222;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_stall got %b exp 0", name, stall); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid got %b exp 1", name, out_valid); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL %s_err got %b exp 1", name, misalign_err); end
    checks++; if ({dmem_req, LMD_out} !== 33'h0) begin errors++; $display("FAIL %s_noreq got req %b lmd %h exp 0/0", name, dmem_req, LMD_out); end
    tick();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL %s_req_later got %b exp 0", name, dmem_req); end
  endtask

  task automatic test_redirect();
    logic [31:0] irs  [4] = '{32'h0000_0063, 32'h0000_1063, 32'h0000_0067, 32'h0000_006F};
    logic        cmp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] alus [4] = '{32'h400, 32'h444, 32'h501, 32'h601};
    logic [31:0] pcs  [4] = '{32'h20, 32'h24, 32'h80, 32'h100};
    logic        e_rd [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] e_pc [4] = '{32'h400, 32'h444, 32'h500, 32'h601};
    logic [31:0] e_alu[4] = '{32'h400, 32'h444, 32'h84, 32'h104};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; IR_in = irs[i]; COMP_in = cmp[i]; ALU_in = alus[i]; PC_in = pcs[i];
      tick();
      checks++; if ({out_valid, redirect} !== {1'b1, e_rd[i]}) begin errors++; $display("FAIL redir_flag[%0d] got v%b r%b exp v1 r%b", i, out_valid, redirect, e_rd[i]); end
      checks++; if (redirect_pc !== e_pc[i]) begin errors++; $display("FAIL redir_pc[%0d] got %h exp %h", i, redirect_pc, e_pc[i]); end
      checks++; if (ALU_out !== e_alu[i]) begin errors++; $display("FAIL redir_alu[%0d] got %h exp %h", i, ALU_out, e_alu[i]); end
    end
    in_valid = 1'b0; COMP_in = 1'b0;
    tick();
  endtask

  task automatic test_stray_ack();
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    tick();
    tick();
    dmem_ack = 1'b0;
    checks++; if ({out_valid, dmem_req, stall} !== 3'b000) begin errors++; $display("FAIL stray_ack got v%b req%b st%b exp 000", out_valid, dmem_req, stall); end
  endtask

  task automatic test_reset_wait();
    in_valid = 1'b1; IR_in = 32'h0000_2003; ALU_in = 32'h300; PC_in = 32'h70;
    tick();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstw_req_before got %b exp 1", dmem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({dmem_req, stall, out_valid} !== 3'b000) begin errors++; $display("FAIL rstw_async got req%b st%b v%b exp 000", dmem_req, stall, out_valid); end
    checks++; if (PC_out !== RST_PC) begin errors++; $display("FAIL rstw_pc got %h exp %h", PC_out, RST_PC); end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({dmem_req, out_valid} !== 2'b00) begin errors++; $display("FAIL rstw_after got req%b v%b exp 00", dmem_req, out_valid); end
    in_valid = 1'b1; IR_in = 32'h0000_00B3; ALU_in = 32'h55; PC_in = 32'h200;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstw_next_stall got %b exp 0", stall); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, ALU_out, PC_out} !== {1'b1, 32'h55, 32'h200}) begin errors++; $display("FAIL rstw_next got v%b alu %h pc %h exp v1 55 200", out_valid, ALU_out, PC_out); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; IR_in = '0; ALU_in = '0; COMP_in = 1'b0;
    PC_in = '0; B_in = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    test_reset();
    test_back_to_back();
    test_load("lb",  3'b000, 32'h103, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h103, 32'h80FF_0000, 3, 32'h0000_0080);
    test_load("lh",  3'b001, 32'h102, 32'h80FF_0000, 2, 32'hFFFF_80FF);
    test_load("lhu", 3'b101, 32'h102, 32'h80FF_0000, 1, 32'h0000_80FF);
    test_load("lw",  3'b010, 32'h300, 32'h1234_5678, 1, 32'h1234_5678);
    test_store("sh", 3'b001, 32'h202, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
    test_store("sb", 3'b000, 32'h201, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    test_store("sw", 3'b010, 32'h204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    test_misalign("lw_mis", 7'b0000011, 3'b010, 32'h301);
    test_misalign("sh_mis", 7'b0100011, 3'b001, 32'h203);
    test_redirect();
    test_stray_ack();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
